// File: rtl/mem_port_arbiter.sv
// Serializes i-side fetches and d-side accesses onto one
// single-ported memory with a fixed access latency.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy,
  output logic                 owner
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic          we_q;
  logic          any_req;
  logic          starved;
  logic          take_i;
  logic          last;

  assign any_req = i_req | d_req;
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));
  // d-side has priority until the fetch side has waited long enough
  assign take_i  = i_req & (~d_req | starved);
  assign last    = (cnt == '0);

  assign m_read  = (state == ACCESS) & ~we_q;
  assign m_write = (state == ACCESS) & we_q;
  assign busy    = (state != IDLE);
  assign i_ack   = (state == RESP) & ~owner;
  assign d_ack   = (state == RESP) & owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        cnt   <= CW'(LATENCY - 1);
        owner <= ~take_i;
        if (take_i) begin
          m_addr     <= i_addr;
          we_q       <= 1'b0;
          starve_cnt <= '0;
        end else begin
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          we_q    <= d_we;
          if (!i_req) begin
            starve_cnt <= '0;
          end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
      end
      if (state == ACCESS) begin
        if (!last) begin
          cnt <= cnt - 1'b1;
        end else if (!we_q) begin
          if (owner) begin
            d_rdata <= m_rdata;
          end else begin
            i_rdata <= m_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-timeline model of the arbiter plus directed
// and random requester traffic.
module tb_mem_port_arbiter;

  localparam int W = 16;
  localparam int L = 2;
  localparam int S = 4;

  logic         clk;
  logic         reset;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_ack;
  logic [W-1:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         m_read;
  logic         m_write;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         busy;
  logic         owner;

  mem_port_arbiter #(
    .WORD_SIZE(W),
    .LATENCY(L),
    .STARVE_LIMIT(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ack(i_ack),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .m_read(m_read),
    .m_write(m_write),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .busy(busy),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory seen by the DUT
  logic [W-1:0] mem_env [256];
  assign m_rdata = mem_env[m_addr[7:0]];

  // reference model state
  logic [W-1:0] ref_mem [256];
  int           g;
  bit           w;
  bit           mwe;
  logic [W-1:0] mdata;
  logic [W-1:0] e_addr;
  logic [W-1:0] e_wdata;
  logic [W-1:0] e_irdata;
  logic [W-1:0] e_drdata;
  bit           e_owner;
  int           streak;
  bit           ei_ack;
  bit           ed_ack;

  int  cyc;
  int  n_chk;
  int  n_fail;
  bit  i_hold;
  bit  d_hold;
  bit  rnd_mode;
  bit  order [$];
  bit  exp4 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    g        = -1000;
    w        = 1'b0;
    mwe      = 1'b0;
    mdata    = '0;
    e_addr   = '0;
    e_wdata  = '0;
    e_irdata = '0;
    e_drdata = '0;
    e_owner  = 1'b0;
    streak   = 0;
  endtask

  // decides the grant made at the end of the current cycle
  task automatic arbitrate();
    bit take_i;
    if (reset) begin
      model_reset();
      return;
    end
    if (cyc < g + L + 2) return;
    if (!i_req && !d_req) return;
    take_i  = i_req && (!d_req || streak == S);
    g       = cyc;
    w       = !take_i;
    e_owner = w;
    if (take_i) begin
      mwe    = 1'b0;
      e_addr = i_addr;
      streak = 0;
    end else begin
      mwe     = d_we;
      e_addr  = d_addr;
      e_wdata = d_wdata;
      streak  = i_req ? ((streak + 1 > S) ? S : streak + 1) : 0;
    end
    if (mwe) ref_mem[e_addr[7:0]] = d_wdata;
    else mdata = ref_mem[e_addr[7:0]];
  endtask

  task automatic compare();
    bit acc;
    bit rsp;
    acc    = (cyc > g) && (cyc <= g + L);
    rsp    = (cyc == g + L + 1);
    ei_ack = rsp && !w;
    ed_ack = rsp && w;
    if (rsp && !mwe) begin
      if (w) e_drdata = mdata;
      else e_irdata = mdata;
    end
    chk("m_read", m_read, acc && !mwe);
    chk("m_write", m_write, acc && mwe);
    chk("busy", busy, acc || rsp);
    chk("i_ack", i_ack, ei_ack);
    chk("d_ack", d_ack, ed_ack);
    chk("owner", owner, e_owner);
    chk("m_addr", m_addr, e_addr);
    chk("m_wdata", m_wdata, e_wdata);
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
  endtask

  task automatic issue();
    if (!i_req && $urandom_range(0, 99) < 25) begin
      i_req  = 1'b1;
      i_addr = W'($urandom_range(0, 255));
    end
    if (!d_req && $urandom_range(0, 99) < 25) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = W'($urandom_range(0, 255));
      d_wdata = W'($urandom);
    end
  endtask

  task automatic tick();
    arbitrate();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (m_write === 1'b1) mem_env[m_addr[7:0]] = m_wdata;
    if (i_ack === 1'b1) order.push_back(1'b0);
    if (d_ack === 1'b1) order.push_back(1'b1);
    if (ei_ack && !i_hold) i_req = 1'b0;
    if (ed_ack && !d_hold) d_req = 1'b0;
    if (rnd_mode) issue();
  endtask

  task automatic set_mem(input int a, input logic [W-1:0] v);
    mem_env[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    cyc      = 0;
    i_hold   = 1'b0;
    d_hold   = 1'b0;
    rnd_mode = 1'b0;
    reset    = 1'b1;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    model_reset();
    for (int i = 0; i < 256; i++) set_mem(i, W'($urandom));
    set_mem(16'h0010, 16'hABCD);
    set_mem(16'h0004, 16'h5555);
    set_mem(16'h0030, 16'h0777);

    tick();
    tick();
    chk("rst_outs", {i_ack, d_ack, m_read, m_write, busy, owner}, 0);
    chk("rst_data", i_rdata | d_rdata | m_addr | m_wdata, 0);
    reset = 1'b0;
    tick();

    // single i-side read
    i_req  = 1'b1;
    i_addr = 16'h0010;
    tick();
    chk("t1_rd1", m_read, 1);
    chk("t1_addr", m_addr, 16'h0010);
    tick();
    chk("t1_rd2", m_read, 1);
    tick();
    chk("t1_ack", i_ack, 1);
    chk("t1_data", i_rdata, 16'hABCD);
    tick();
    chk("t1_busy", busy, 0);

    // simultaneous requests
    i_req  = 1'b1;
    i_addr = 16'h0030;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0004;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) begin
        chk("t2_dack", d_ack, 1);
        chk("t2_ddata", d_rdata, 16'h5555);
        chk("t2_own_d", owner, 1);
      end
      if (t == 7) begin
        chk("t2_iack", i_ack, 1);
        chk("t2_idata", i_rdata, 16'h0777);
        chk("t2_own_i", owner, 0);
      end
    end

    // write then read back
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1 || t == 2) chk("t3_wr", m_write, 1);
      if (t == 3) begin
        chk("t3_dack", d_ack, 1);
        chk("t3_keep", d_rdata, 16'h5555);
        i_req  = 1'b1;
        i_addr = 16'h0020;
      end
      if (t == 7) begin
        chk("t3_iack", i_ack, 1);
        chk("t3_idata", i_rdata, 16'h1234);
      end
    end

    // starvation guard with both requests held
    i_hold = 1'b1;
    d_hold = 1'b1;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0004;
    order.delete();
    for (int t = 0; t < 100 && order.size() < 10; t++) begin
      tick();
      chk("t4_single", i_ack & d_ack, 0);
    end
    i_hold = 1'b0;
    d_hold = 1'b0;
    i_req  = 1'b0;
    d_req  = 1'b0;
    chk("t4_count", W'(order.size()), 10);
    for (int k = 0; k < 10 && k < order.size(); k++) begin
      chk($sformatf("t4_order%0d", k), order[k], exp4[k]);
    end

    // reset in the middle of an i read
    i_req  = 1'b1;
    i_addr = 16'h0010;
    tick();
    tick();
    tick();
    chk("t5_rd", m_read, 1);
    reset = 1'b1;
    i_req = 1'b0;
    tick();
    chk("t5_rd0", m_read, 0);
    chk("t5_outs", {i_ack, d_ack, m_write, busy, owner}, 0);
    chk("t5_data", i_rdata | d_rdata | m_addr | m_wdata, 0);
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t5_noack", i_ack, 0);
    end
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0004;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 3) begin
        chk("t5_dack", d_ack, 1);
        chk("t5_ddata", d_rdata, 16'h5555);
      end
    end

    // no requests
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("t6_quiet", {m_read, m_write, busy, i_ack, d_ack}, 0);
    end

    // random traffic
    rnd_mode = 1'b1;
    for (int t = 0; t < 3000; t++) tick();
    rnd_mode = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!i_req && !d_req && cyc >= g + L + 2) break;
      tick();
    end
    chk("drained", {i_req, d_req}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
